// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, framing FSM encoding and the
// bit-period helper used by both the transmitter and the receiver.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } uart_state_e;

  // Clock cycles per line bit; integer division, so the line rate rounds up.
  function automatic int baud_cnt_max(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/level flags. A write into a
// full FIFO succeeds only when a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      level_o
);

  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd_en_i && !empty_q;
    do_wr    = wr_en_i && (!full_q || do_rd);
    wr_ptr_d = do_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    case ({do_wr, do_rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    full_d  = (level_d == FULL_LVL);
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes strobed into a FIFO are framed
// (start, 8 data LSB first, optional parity, stop) back-to-back on tx.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int UART_BPS   = 9600,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [7:0]                  pi_data,
  input  logic                        pi_flag,
  output logic                        tx,
  output logic                        busy,
  output logic                        fifo_full,
  output logic                        fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow
);

  localparam int BAUD_MAX = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam int CNT_W    = (BAUD_MAX > 1) ? $clog2(BAUD_MAX) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_MAX - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic             tx_q, tx_d;
  logic             ovf_q, ovf_d;
  logic             bit_end;
  logic             fifo_rd, fifo_wr;
  logic [7:0]       fifo_rdata;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (pi_data),
    .rd_en_i   (fifo_rd),
    .rd_data_o (fifo_rdata),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + CNT_ONE;
    bit_d   = bit_q;
    data_d  = data_q;
    par_d   = par_q;
    fifo_rd = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          data_d  = fifo_rdata;
          par_d   = (PARITY == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
        end
      end
      ST_PAR: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // tx is registered from next-state values so the line tracks state_q.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = data_d[bit_d];
      ST_PAR:   tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase

    // A full FIFO still takes a write when the FSM pops in the same cycle.
    fifo_wr = pi_flag && (!fifo_full || fifo_rd);
    ovf_d   = pi_flag && !fifo_wr;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= 3'd0;
      data_q  <= 8'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = (state_q != ST_IDLE);
  assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: three instances (no, even, odd parity)
// at 10 cycles per bit with a 4-deep FIFO, checked cycle by cycle.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] flag;
  logic [7:0] data [3];
  logic [2:0] tx_w, busy_w, full_w, empty_w, ovf_w;
  logic [2:0] level_w [3];
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  // Instance 0: no parity, 1: even parity, 2: odd parity.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_fifo #(
      .UART_BPS   (100_000),
      .CLK_FREQ   (1_000_000),
      .FIFO_DEPTH (4),
      .PARITY     ((g == 0) ? 0 : ((g == 1) ? 2 : 1))
    ) dut (
      .sys_clk    (clk),
      .sys_rst    (rst),
      .pi_data    (data[g]),
      .pi_flag    (flag[g]),
      .tx         (tx_w[g]),
      .busy       (busy_w[g]),
      .fifo_full  (full_w[g]),
      .fifo_empty (empty_w[g]),
      .fifo_level (level_w[g]),
      .overflow   (ovf_w[g])
    );
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks tx/busy for frame cycles skip..stop_k-1, where cycle 0 is the first start-bit cycle.
  task automatic frame(input int d, input logic [7:0] b, input bit has_par, input logic pbit,
                       input int skip, input int stop_k, input string tag);
    logic [10:0] bits;
    bits = has_par ? {1'b1, pbit, b, 1'b0} : {1'b1, 1'b1, b, 1'b0};
    for (int k = skip; k < stop_k; k++) begin
      chk({tag, " tx"}, 32'(tx_w[d]), 32'(bits[k / 10]));
      chk({tag, " busy"}, 32'(busy_w[d]), 32'd1);
      step();
    end
  endtask

  task automatic idle_chk(input int d, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, " idle tx"}, 32'(tx_w[d]), 32'd1);
      chk({tag, " idle busy"}, 32'(busy_w[d]), 32'd0);
      step();
    end
  endtask

  initial begin
    rst  = 1'b1;
    flag = 3'b000;
    for (int i = 0; i < 3; i++) data[i] = 8'h00;
    repeat (3) step();

    for (int d = 0; d < 3; d++) begin
      chk("rst tx", 32'(tx_w[d]), 32'd1);
      chk("rst busy", 32'(busy_w[d]), 32'd0);
      chk("rst empty", 32'(empty_w[d]), 32'd1);
      chk("rst full", 32'(full_w[d]), 32'd0);
      chk("rst level", 32'(level_w[d]), 32'd0);
      chk("rst overflow", 32'(ovf_w[d]), 32'd0);
    end
    rst = 1'b0;
    step();

    // Single byte 0xA5, no parity: start bit 2 cycles after the strobe.
    flag[0] = 1'b1; data[0] = 8'hA5;
    step();
    flag[0] = 1'b0;
    chk("wr level", 32'(level_w[0]), 32'd1);
    chk("wr empty", 32'(empty_w[0]), 32'd0);
    chk("wr tx", 32'(tx_w[0]), 32'd1);
    chk("wr busy", 32'(busy_w[0]), 32'd0);
    step();
    chk("pop empty", 32'(empty_w[0]), 32'd1);
    chk("pop level", 32'(level_w[0]), 32'd0);
    frame(0, 8'hA5, 1'b0, 1'b0, 0, 100, "a5");
    idle_chk(0, 5, "a5");

    // Even parity: 0x07 -> parity bit 1.
    flag[1] = 1'b1; data[1] = 8'h07;
    step();
    flag[1] = 1'b0;
    step();
    frame(1, 8'h07, 1'b1, 1'b1, 0, 110, "even");
    idle_chk(1, 5, "even");

    // Odd parity: 0x07 -> parity bit 0.
    flag[2] = 1'b1; data[2] = 8'h07;
    step();
    flag[2] = 1'b0;
    step();
    frame(2, 8'h07, 1'b1, 1'b0, 0, 110, "odd");
    idle_chk(2, 5, "odd");

    // Burst of 6 strobes: 0x01 popped at once, 0x02..0x05 fill, 0x06 dropped.
    flag[0] = 1'b1; data[0] = 8'h01;
    step();
    chk("burst lvl1", 32'(level_w[0]), 32'd1);
    chk("burst empty", 32'(empty_w[0]), 32'd0);
    data[0] = 8'h02;
    step();
    chk("burst lvl2", 32'(level_w[0]), 32'd1);
    chk("burst start", 32'(tx_w[0]), 32'd0);
    data[0] = 8'h03;
    step();
    chk("burst lvl3", 32'(level_w[0]), 32'd2);
    data[0] = 8'h04;
    step();
    chk("burst lvl4", 32'(level_w[0]), 32'd3);
    data[0] = 8'h05;
    step();
    chk("burst lvl5", 32'(level_w[0]), 32'd4);
    chk("burst full", 32'(full_w[0]), 32'd1);
    chk("burst no ovf", 32'(ovf_w[0]), 32'd0);
    data[0] = 8'h06;
    step();
    flag[0] = 1'b0;
    chk("burst ovf", 32'(ovf_w[0]), 32'd1);
    chk("burst lvl6", 32'(level_w[0]), 32'd4);
    step();
    chk("burst ovf end", 32'(ovf_w[0]), 32'd0);
    frame(0, 8'h01, 1'b0, 1'b0, 5, 100, "b01");
    for (int v = 2; v <= 5; v++) begin
      idle_chk(0, 1, "burst");
      frame(0, 8'(v), 1'b0, 1'b0, 0, 100, "burst");
    end
    for (int i = 0; i < 40; i++) begin
      chk("drop tx", 32'(tx_w[0]), 32'd1);
      chk("drop busy", 32'(busy_w[0]), 32'd0);
      chk("drop level", 32'(level_w[0]), 32'd0);
      step();
    end

    // Fill to 4 behind a running frame, then write in the cycle IDLE pops.
    flag[0] = 1'b1; data[0] = 8'h11;
    step();
    data[0] = 8'h22;
    step();
    data[0] = 8'h33;
    step();
    data[0] = 8'h44;
    step();
    data[0] = 8'h55;
    step();
    flag[0] = 1'b0;
    chk("fill level", 32'(level_w[0]), 32'd4);
    chk("fill full", 32'(full_w[0]), 32'd1);
    frame(0, 8'h11, 1'b0, 1'b0, 3, 100, "f11");
    chk("pop cycle busy", 32'(busy_w[0]), 32'd0);
    chk("pop cycle level", 32'(level_w[0]), 32'd4);
    flag[0] = 1'b1; data[0] = 8'h5A;
    step();
    flag[0] = 1'b0;
    chk("full wr ovf", 32'(ovf_w[0]), 32'd0);
    chk("full wr level", 32'(level_w[0]), 32'd4);
    chk("full wr full", 32'(full_w[0]), 32'd1);
    chk("full wr start", 32'(tx_w[0]), 32'd0);
    step();
    frame(0, 8'h22, 1'b0, 1'b0, 1, 100, "f22");
    idle_chk(0, 1, "f");
    frame(0, 8'h33, 1'b0, 1'b0, 0, 100, "f33");
    idle_chk(0, 1, "f");
    frame(0, 8'h44, 1'b0, 1'b0, 0, 100, "f44");
    idle_chk(0, 1, "f");
    frame(0, 8'h55, 1'b0, 1'b0, 0, 100, "f55");
    idle_chk(0, 1, "f");
    frame(0, 8'h5A, 1'b0, 1'b0, 0, 100, "f5a");
    chk("drain empty", 32'(empty_w[0]), 32'd1);
    idle_chk(0, 3, "drain");

    // Reset during data bit 3 of 0x00 with two bytes still queued.
    flag[0] = 1'b1; data[0] = 8'h00;
    step();
    data[0] = 8'hFF;
    step();
    step();
    flag[0] = 1'b0;
    chk("pre-rst level", 32'(level_w[0]), 32'd2);
    frame(0, 8'h00, 1'b0, 1'b0, 1, 45, "r00");
    chk("pre-rst bit3", 32'(tx_w[0]), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post-rst tx", 32'(tx_w[0]), 32'd1);
    chk("post-rst busy", 32'(busy_w[0]), 32'd0);
    chk("post-rst level", 32'(level_w[0]), 32'd0);
    chk("post-rst empty", 32'(empty_w[0]), 32'd1);
    for (int i = 0; i < 150; i++) begin
      chk("after-rst tx", 32'(tx_w[0]), 32'd1);
      chk("after-rst busy", 32'(busy_w[0]), 32'd0);
      chk("after-rst level", 32'(level_w[0]), 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered UART transmitter: accepts bytes through a single-cycle strobe into an internal FIFO and serialises them back-to-back on `tx`. Each frame is one start bit, 8 data bits LSB first, an optional parity bit and one stop bit. It is the host-facing send end of the serial link. It replaces the unbuffered transmitter wherever a producer emits bursts faster than the line rate, such as reply strings or status dumps.

## Interface
- `UART_BPS`, 'd9600, line bit rate.
- `CLK_FREQ`, 'd50_000_000, `sys_clk` frequency in Hz.
- `FIFO_DEPTH`, 16, byte capacity; must be a power of two, ≥ 2.
- `PARITY`, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- `sys_clk`  in  1  single clock; all logic on its rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `pi_data`  in  8  byte to send; sampled when `pi_flag` = 1.
- `pi_flag`  in  1  one-cycle write strobe.
- `tx`  out  1  serial line; idle high.
- `busy`  out  1  high while a frame is on the line.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` bytes.
- `fifo_empty`  out  1  FIFO holds no bytes.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  number of bytes queued.
- `overflow`  out  1  one-cycle pulse when a strobed byte is dropped.

## Operation
- **Bit period:** `BAUD_CNT_MAX = CLK_FREQ/UART_BPS`, integer division.
  - A baud counter runs from 0 to `BAUD_CNT_MAX-1`; each line bit lasts exactly `BAUD_CNT_MAX` cycles.
  - The counter is held at 0 in IDLE.
- **FSM states:** IDLE, START, DATA, PAR, STOP.
  - IDLE → START when `fifo_empty` = 0. In the same cycle: pop the head byte into the shift register, and latch parity = ^byte (odd mode: inverted).
  - START → DATA after one bit period.
  - DATA shifts out 8 bits, LSB first; a 3-bit counter selects the bit.
  - After bit 7, DATA → PAR if `PARITY` ≠ 0, otherwise DATA → STOP.
  - PAR → STOP after one bit period.
  - STOP → IDLE after one bit period.
- **Line levels:** `tx` is registered. It is 0 in START, the data or parity bit in DATA/PAR, and 1 in STOP and IDLE.
- **Busy:** `busy` = 1 in START, DATA, PAR and STOP.
- **Writes:**
  - A write is accepted when `pi_flag` = 1 and (`fifo_full` = 0 or a pop occurs in the same cycle).
  - Otherwise the byte is discarded and `overflow` pulses in the next cycle.
- **Simultaneous write and pop:** level is unchanged and pointers both advance; this applies at both full and empty.
- **Pointers:** write and read pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - `fifo_level` is a separate counter.
  - `fifo_full` = (level == DEPTH); `fifo_empty` = (level == 0).
- **Reset values:** `tx` = 1, `busy` = 0, `fifo_empty` = 1, `fifo_full` = 0, `fifo_level` = 0, `overflow` = 0. Pointers are 0 and the FSM is in IDLE.
- **Reset mid-frame:** the frame is aborted. `tx` = 1 from the first cycle after the reset edge, all queued bytes are lost, and no partial frame resumes.

## Timing
- **Write:** `pi_flag` high in cycle N (FIFO empty, IDLE) → byte stored at the end of N.
  - `fifo_empty` = 0 and `fifo_level` = 1 in cycle N+1.
- **Pop:** in cycle N+1 the FSM pops; `fifo_empty` = 1 again in N+2.
- **First edge on the line:** `tx` falls to 0 in cycle N+2, so write-to-start-bit latency is 2 cycles.
- **Frame length:** (10 + (`PARITY` ≠ 0)) × `BAUD_CNT_MAX` cycles, measured from the `tx` falling edge to the first cycle after the stop bit.
- **Back-to-back frames:** with the FIFO non-empty at the end of STOP, the next start bit begins 1 cycle after the stop bit ends (the IDLE cycle). The inter-frame gap is therefore exactly `BAUD_CNT_MAX` + 1 high cycles, including the stop bit.
- **Status flags:** `fifo_full`, `fifo_empty` and `fifo_level` are registered and reflect the writes and pops of the previous cycle.

## Structure
- **Shared package `uart_pkg`:**
  - parity mode constants `PAR_NONE`, `PAR_ODD`, `PAR_EVEN`;
  - the FSM state encoding;
  - the `BAUD_CNT_MAX` function of `CLK_FREQ`/`UART_BPS`, so the receiver uses the same definition.
- **Sub-module `sync_fifo`** (parameters: width 8, `FIFO_DEPTH`): synchronous-reset, single-clock FIFO with `wr_en`, `rd_en`, `full`, `empty` and `level`. All framing logic stays in `uart_tx_fifo`.

## Test plan
Bench parameters: `CLK_FREQ` = 1_000_000, `UART_BPS` = 100_000 (10 cycles/bit), `FIFO_DEPTH` = 4.
- **Single byte:** `PARITY` = 0, write 0xA5.
  - `tx` falls 2 cycles later, then 1,0,1,0,0,1,0,1 at 10 cycles each, then stop = 1.
  - `busy` is high for exactly 100 cycles.
- **Parity:** `PARITY` = 2, write 0x07 → parity bit 1. `PARITY` = 1, write 0x07 → parity bit 0. Each frame is 110 cycles.
- **Burst and overflow:** 6 consecutive strobes 0x01..0x06 while idle.
  - 0x01 is popped immediately, 0x02..0x05 fill the FIFO, 0x06 is dropped with a one-cycle `overflow` pulse.
  - Five frames are sent back-to-back, each start bit 11 cycles after the previous stop bit begins.
- **Write while full with simultaneous pop:** strobe in the exact cycle IDLE pops from a full FIFO → byte accepted, `overflow` stays 0, `fifo_level` stays 4.
- **Reset mid-frame:** assert `sys_rst` for 1 cycle during data bit 3 of 0x00 with 2 bytes queued.
  - Next cycle: `tx` = 1, `busy` = 0, `fifo_level` = 0.
  - No further frames are sent.
